// File: rtl/fixed_point_pkg.sv
// Shared Q10.21 fixed-point constants, divider state type and magnitude helper.
package fixed_point_pkg;

    localparam int WIDTH = 32;
    localparam int FRAC  = 21;

    localparam logic [WIDTH-1:0] Q_MAX = 32'h7FFFFFFF;
    localparam logic [WIDTH-1:0] Q_MIN = 32'h80000000;
    localparam logic [WIDTH-1:0] ONE   = 32'h00200000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } div_state_t;

    // Unsigned magnitude of a two's-complement word; the most negative value maps to 2^31.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/fixed_divider_step.sv
// One restoring shift-subtract iteration: shift in a numerator bit, subtract if it fits.
module div_step
    import fixed_point_pkg::*;
(
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] divisor,
    input  logic             num_bit,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;

    assign shifted = {rem, num_bit};
    assign q_bit   = (shifted >= {1'b0, divisor});

    // The true difference is below the divisor, so the low WIDTH bits are exact.
    assign rem_next = q_bit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];

endmodule

// File: rtl/fixed_divider.sv
// Sequential signed Q10.21 divider: one quotient bit per cycle, start/busy/valid handshake.
module fixed_divider
    import fixed_point_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             dbz
);

    localparam int NUM_W = WIDTH + FRAC;
    localparam logic [5:0]       LAST_COUNT = 6'(NUM_W - 1);
    localparam logic [NUM_W-1:0] POS_LIM    = NUM_W'(Q_MAX);
    localparam logic [NUM_W-1:0] NEG_LIM    = NUM_W'(Q_MIN);

    div_state_t       state;
    logic [5:0]       count;
    logic             sign;
    logic [WIDTH-1:0] b_abs;
    logic [NUM_W-1:0] num;
    logic [WIDTH-1:0] rem;
    logic [NUM_W-1:0] quo;

    logic [WIDTH-1:0] rem_next;
    logic             q_bit;

    logic [WIDTH-1:0] fin_result;
    logic             fin_ovf;
    logic             fin_dbz;

    div_step u_step (
        .rem      (rem),
        .divisor  (b_abs),
        .num_bit  (num[NUM_W-1]),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // Sign, saturation and divide-by-zero handling of the finished magnitude quotient.
    always_comb begin
        fin_result = '0;
        fin_ovf    = 1'b0;
        fin_dbz    = 1'b0;
        if (b_abs == '0) begin
            fin_dbz    = 1'b1;
            fin_result = sign ? Q_MIN : Q_MAX;
        end else if (!sign) begin
            if (quo > POS_LIM) begin
                fin_result = Q_MAX;
                fin_ovf    = 1'b1;
            end else begin
                fin_result = quo[WIDTH-1:0];
            end
        end else begin
            if (quo > NEG_LIM) begin
                fin_result = Q_MIN;
                fin_ovf    = 1'b1;
            end else begin
                fin_result = ~quo[WIDTH-1:0] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            sign   <= 1'b0;
            b_abs  <= '0;
            num    <= '0;
            rem    <= '0;
            quo    <= '0;
            busy   <= 1'b0;
            valid  <= 1'b0;
            result <= '0;
            ovf    <= 1'b0;
            dbz    <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign  <= a[WIDTH-1] ^ b[WIDTH-1];
                        b_abs <= abs_val(b);
                        num   <= {abs_val(a), {FRAC{1'b0}}};
                        rem   <= '0;
                        quo   <= '0;
                        count <= LAST_COUNT;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    rem   <= rem_next;
                    quo   <= {quo[NUM_W-2:0], q_bit};
                    num   <= {num[NUM_W-2:0], 1'b0};
                    count <= count - 1'b1;
                    if (count == '0) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    result <= fin_result;
                    ovf    <= fin_ovf;
                    dbz    <= fin_dbz;
                    valid  <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_divider.sv
// Self-checking bench for fixed_divider: directed cases, random operands, abort and back-to-back.
module tb_fixed_divider;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        valid;
    logic [31:0] result;
    logic        ovf;
    logic        dbz;

    int errors = 0;
    int checks = 0;

    fixed_divider dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .valid  (valid),
        .result (result),
        .ovf    (ovf),
        .dbz    (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer quotient of (|a| * 2^21) / |b|, truncated, signed, saturated.
    function automatic void model(input logic [31:0] ma, input logic [31:0] mb,
                                  output logic [31:0] r, output logic o, output logic d);
        longint sa, sb;
        longint unsigned aa, bb, q, nq;
        logic neg;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        aa = (sa < 0) ? longint'(-sa) : longint'(sa);
        bb = (sb < 0) ? longint'(-sb) : longint'(sb);
        neg = ma[31] ^ mb[31];
        o = 1'b0;
        d = 1'b0;
        if (mb == 32'h0) begin
            d = 1'b1;
            r = ma[31] ? 32'h80000000 : 32'h7FFFFFFF;
        end else begin
            q = (aa * 64'd2097152) / bb;
            if (!neg) begin
                if (q > 64'h7FFFFFFF) begin
                    r = 32'h7FFFFFFF;
                    o = 1'b1;
                end else begin
                    r = 32'(q);
                end
            end else begin
                if (q > 64'h80000000) begin
                    r = 32'h80000000;
                    o = 1'b1;
                end else begin
                    nq = 64'd0 - q;
                    r = 32'(nq);
                end
            end
        end
    endfunction

    // Launch one division; optionally pulse a competing start inject_at cycles later.
    task automatic applyStimulus(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                                 input int inject_at, input logic [31:0] ia, input logic [31:0] ib);
        logic [31:0] er;
        logic eo, ed;
        int lat, busy_cnt;
        model(ta, tb_, er, eo, ed);
        @(negedge clk);
        a = ta;
        b = tb_;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        lat = 0;
        busy_cnt = 0;
        while (valid !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) busy_cnt++;
            start = (lat == inject_at);
            if (start) begin
                a = ia;
                b = ib;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        checkOutput({tag, " latency"}, 32'(lat), 32'd54);
        checkOutput({tag, " busy cycles"}, 32'(busy_cnt), 32'd54);
        checkOutput({tag, " busy at valid"}, {31'b0, busy}, 32'd0);
        checkOutput({tag, " result"}, result, er);
        checkOutput({tag, " ovf"}, {31'b0, ovf}, {31'b0, eo});
        checkOutput({tag, " dbz"}, {31'b0, dbz}, {31'b0, ed});
    endtask

    initial begin
        logic [31:0] ra, rb, er;
        logic eo, ed;
        int cnt, vcount;

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", {31'b0, busy}, 32'd0);
        checkOutput("reset valid", {31'b0, valid}, 32'd0);
        checkOutput("reset result", result, 32'd0);
        checkOutput("reset flags", {30'b0, ovf, dbz}, 32'd0);
        rst = 1'b0;

        applyStimulus("6/2", 32'h00C00000, 32'h00400000, -1, 0, 0);
        checkOutput("6/2 literal", result, 32'h00600000);
        applyStimulus("1/3", 32'h00200000, 32'h00600000, -1, 0, 0);
        checkOutput("1/3 literal", result, 32'h000AAAAA);
        applyStimulus("-1/3", 32'hFFE00000, 32'h00600000, -1, 0, 0);
        checkOutput("-1/3 literal", result, 32'hFFF55556);
        applyStimulus("-1/4", 32'hFFE00000, 32'h00800000, -1, 0, 0);
        checkOutput("-1/4 literal", result, 32'hFFF80000);
        applyStimulus("min/1", 32'h80000000, 32'h00200000, -1, 0, 0);
        checkOutput("min/1 literal", result, 32'h80000000);
        applyStimulus("big/ulp", 32'h7D000000, 32'h00000001, -1, 0, 0);
        checkOutput("big/ulp literal", {result[31:1], ovf}, {31'h3FFFFFFF, 1'b1});
        applyStimulus("-big/ulp", 32'h83000000, 32'h00000001, -1, 0, 0);
        checkOutput("-big/ulp literal", {result[31:1], ovf}, {31'h40000000, 1'b1});
        applyStimulus("-1/0", 32'hFFE00000, 32'h00000000, -1, 0, 0);
        checkOutput("-1/0 literal", {result[31:1], dbz}, {31'h40000000, 1'b1});
        applyStimulus("0/0", 32'h00000000, 32'h00000000, -1, 0, 0);
        checkOutput("0/0 literal", {result[31:1], dbz}, {31'h3FFFFFFF, 1'b1});

        // Competing start mid-run must be dropped.
        applyStimulus("ignored start", 32'h00C00000, 32'h00400000, 10, 32'h00200000, 32'h00600000);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom >> $urandom_range(0, 20);
            rb = $urandom >> $urandom_range(0, 24);
            if ($urandom_range(0, 1) == 1) ra = ~ra + 1'b1;
            if ($urandom_range(0, 1) == 1) rb = ~rb + 1'b1;
            if ($urandom_range(0, 9) == 0) rb = 32'h0;
            applyStimulus($sformatf("rand%0d", i), ra, rb, -1, 0, 0);
        end

        // Abort at cycle 20 of a run.
        @(negedge clk);
        a = 32'h00C00000;
        b = 32'h00400000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort busy", {31'b0, busy}, 32'd0);
        checkOutput("abort valid", {31'b0, valid}, 32'd0);
        checkOutput("abort result", result, 32'd0);
        checkOutput("abort flags", {30'b0, ovf, dbz}, 32'd0);
        vcount = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (valid === 1'b1) vcount++;
        end
        checkOutput("abort no valid", 32'(vcount), 32'd0);

        // Back-to-back: new start presented in the valid cycle.
        applyStimulus("b2b first", 32'h00200000, 32'h00600000, -1, 0, 0);
        a = 32'hFFE00000;
        b = 32'h00800000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 1;
        checkOutput("b2b accepted", {31'b0, busy}, 32'd1);
        while (valid !== 1'b1 && cnt < 120) begin
            @(negedge clk);
            cnt++;
        end
        model(32'hFFE00000, 32'h00800000, er, eo, ed);
        checkOutput("b2b spacing", 32'(cnt), 32'd55);
        checkOutput("b2b result", result, er);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fixed_divider.md
# fixed_divider

Sequential signed fixed-point divider for the Q10.21 datapath (1 sign bit, 10 integer bits, 21 fractional bits). It is the inverse companion to the pipelined multiplier: it computes result = a / b in the same format. It uses a restoring shift-subtract algorithm, one quotient bit per cycle, behind a start/busy/valid handshake. The accelerator control sequences it wherever a quotient is required.

## Interface
- WIDTH, 32, operand and result width
- FRAC, 21, number of fractional bits
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- start  in  1  request; sampled only while busy=0
- a  in  WIDTH  dividend, two's-complement Q10.21
- b  in  WIDTH  divisor, two's-complement Q10.21
- busy  out  1  high from the edge that accepts start until the edge that raises valid
- valid  out  1  one-cycle pulse; result and flags are valid in that cycle
- result  out  WIDTH  quotient, Q10.21; held until the next accepted start
- ovf  out  1  quotient saturated; held with result
- dbz  out  1  divide by zero; held with result

## Operation
- States: IDLE, RUN, FINISH.
- IDLE:
  - When start=1, latch sign = a[MSB]^b[MSB], |a| and |b| as WIDTH-bit unsigned. |0x80000000| = 2^31.
  - Clear the remainder, load count = WIDTH+FRAC-1 (52), and go to RUN.
- RUN, once per cycle:
  - Shift the next numerator bit into the remainder. The numerator is the (WIDTH+FRAC)-bit value |a| << FRAC, MSB first.
  - If remainder ≥ |b|, subtract and shift 1 into the quotient; otherwise shift 0.
  - Decrement count. After the iteration at count=0, go to FINISH.
- FINISH:
  - Form the 53-bit magnitude quotient Q.
  - Register result, ovf and dbz, pulse valid, and go to IDLE.
- Rounding: truncate magnitude toward zero, then apply sign; i.e. result = sign ? -Q : Q.
- Saturation:
  - Positive result with Q > 2^31-1 gives 0x7FFFFFFF, ovf=1.
  - Negative result with Q > 2^31 gives 0x80000000, ovf=1.
  - Q = 2^31 negative is exact: 0x80000000, ovf=0.
- Divide by zero (b=0):
  - Iterations still run, so latency stays fixed.
  - Result is 0x7FFFFFFF if a ≥ 0, else 0x80000000. dbz=1, ovf=0.
  - 0/0 gives 0x7FFFFFFF, dbz=1.
- start while busy=1 is ignored, with no queueing. Operands a and b are don't-care except in the accept cycle.
- valid and start may coincide in the same cycle; the new request is accepted at the following edge (busy=0 in that cycle).

## Timing
- Reset values: state=IDLE, busy=0, valid=0, result=0, ovf=0, dbz=0, all internal registers 0.
- rst=1 during RUN or FINISH aborts: valid is never pulsed for the aborted request, and all outputs return to their reset values at that edge.
- Edge E0 samples start=1; busy=1 from E0.
- Iteration edges are E1..E53. Edge E54 registers the result; valid=1 and busy=0 in the cycle after E54.
- Fixed latency: 54 cycles from the accept edge to valid, for all operands including b=0.
- Throughput: one division per 55 cycles with back-to-back starts.

## Structure
- Shared package fixed_point_pkg holds:
  - constants WIDTH=32, FRAC=21, Q_MAX=32'h7FFFFFFF, Q_MIN=32'h80000000, ONE=32'h00200000;
  - typedef enum div_state_t {IDLE, RUN, FINISH}.
- One combinational sub-module, div_step:
  - inputs: remainder, divisor, next numerator bit;
  - outputs: next remainder, quotient bit.
- Sign/abs, saturation and the FSM stay in fixed_divider.

## Test plan
- a=0x00C00000 (6.0), b=0x00400000 (2.0), start one cycle -> busy high 54 cycles; valid pulse after E54; result=0x00600000 (3.0), ovf=0, dbz=0.
- a=0x00200000 (1.0), b=0x00600000 (3.0) -> 0x000AAAAA. a=0xFFE00000 (-1.0), same b -> 0xFFF55556 (truncation toward zero).
- a=0xFFE00000 (-1.0), b=0x00800000 (4.0) -> 0xFFF80000 (-0.25). a=0x80000000, b=0x00200000 -> 0x80000000, ovf=0.
- a=0x7D000000 (1000.0), b=0x00000001 -> 0x7FFFFFFF, ovf=1. Negate a -> 0x80000000, ovf=1.
- b=0 with a=0xFFE00000 -> 0x80000000, dbz=1, still at 54 cycles. b=0 with a=0 -> 0x7FFFFFFF, dbz=1.
- Second start at cycle 10 with different operands -> ignored, first result returned.
- rst at cycle 20 of RUN -> busy=0 and outputs zero next cycle; no valid.
- New start in the valid cycle -> accepted, next valid 55 cycles after the first.
